// File: rtl/sha256_byte_packer.sv
// SHA-256 message packer: turns a byte stream into big-endian word writes for
// a 16-word block buffer, appends 0x80 / zero fill / 64-bit bit length, and
// signals each completed block to the compression stage.
module sha256_byte_packer #(
  parameter int LEN_W = 16
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        msg_empty,
  input  logic        buf_free,
  output logic        out_wr,
  output logic [3:0]  out_addr,
  output logic [3:0]  out_en,
  output logic [31:0] out_data,
  output logic        blk_done,
  output logic        msg_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_WAIT, S_DATA, S_PAD, S_ZF, S_LEN0, S_LEN1, S_BLK
  } state_t;

  state_t           state, state_nx;
  logic [5:0]       p, p_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  // zero-fill pointer holds the last word written; 5'h1F means "start at word 0"
  logic [4:0]       zw, zw_nx, tgt, tgt_nx;
  logic             pend_pad, pend_pad_nx, pend_ovf, pend_ovf_nx;
  logic             last, last_nx, err_nx;
  logic             wr_nx, blk_nx, msg_nx;
  logic [3:0]       addr_nx, en_nx;
  logic [31:0]      data_nx;
  logic [4:0]       zw_inc;
  logic [63:0]      bitlen;

  // Lanes from the pad byte down to the least significant byte
  function automatic logic [3:0] pad_en(input logic [1:0] lane);
    return 4'b1111 >> lane;
  endfunction

  // 0x80 placed in the given lane, zeros in the lower lanes
  function automatic logic [31:0] pad_word(input logic [1:0] lane);
    return 32'h8000_0000 >> {lane, 3'b000};
  endfunction

  assign in_ready = (state == S_DATA);
  assign zw_inc   = zw + 5'd1;
  assign bitlen   = {{(61 - LEN_W){1'b0}}, cnt, 3'b000};

  // Next-state, counters and next registered outputs
  always_comb begin
    state_nx    = state;
    p_nx        = p;
    cnt_nx      = cnt;
    zw_nx       = zw;
    tgt_nx      = tgt;
    pend_pad_nx = pend_pad;
    pend_ovf_nx = pend_ovf;
    last_nx     = last;
    err_nx      = err;
    wr_nx       = 1'b0;
    addr_nx     = 4'd0;
    en_nx       = 4'd0;
    data_nx     = 32'd0;
    blk_nx      = 1'b0;
    msg_nx      = 1'b0;
    case (state)
      S_WAIT: begin
        if (msg_empty) pend_pad_nx = 1'b1;
        if (buf_free) begin
          if (pend_ovf) begin
            // second block of an overflowed pad: zero words 0..13 then length
            pend_ovf_nx = 1'b0;
            zw_nx       = 5'h1F;
            tgt_nx      = 5'd13;
            state_nx    = S_ZF;
          end else if (pend_pad || msg_empty) begin
            pend_pad_nx = 1'b0;
            state_nx    = S_PAD;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (in_valid) begin
          wr_nx   = 1'b1;
          addr_nx = p[5:2];
          en_nx   = 4'b1000 >> p[1:0];
          data_nx = {4{in_data}};
          p_nx    = p + 6'd1;
          cnt_nx  = cnt + LEN_W'(1);
          if (&cnt) err_nx = 1'b1;
          if (in_last) begin
            // last byte filling the block: pad goes into a fresh block
            if (&p) begin
              pend_pad_nx = 1'b1;
              state_nx    = S_BLK;
            end else begin
              state_nx = S_PAD;
            end
          end else if (&p) begin
            state_nx = S_BLK;
          end
        end else if (msg_empty && p == 6'd0) begin
          state_nx = S_PAD;
        end
      end
      S_PAD: begin
        wr_nx   = 1'b1;
        addr_nx = p[5:2];
        en_nx   = pad_en(p[1:0]);
        data_nx = pad_word(p[1:0]);
        zw_nx   = {1'b0, p[5:2]};
        if (p[5:2] <= 4'd13) begin
          tgt_nx = 5'd13;
        end else begin
          // no room for the length: finish this block with zeros
          tgt_nx      = 5'd15;
          pend_ovf_nx = 1'b1;
        end
        state_nx = S_ZF;
      end
      S_ZF: begin
        if (zw == tgt) begin
          state_nx = (tgt == 5'd13) ? S_LEN0 : S_BLK;
        end else begin
          wr_nx   = 1'b1;
          addr_nx = zw_inc[3:0];
          en_nx   = 4'hF;
          zw_nx   = zw_inc;
        end
      end
      S_LEN0: begin
        wr_nx    = 1'b1;
        addr_nx  = 4'd14;
        en_nx    = 4'hF;
        data_nx  = bitlen[63:32];
        state_nx = S_LEN1;
      end
      S_LEN1: begin
        wr_nx    = 1'b1;
        addr_nx  = 4'd15;
        en_nx    = 4'hF;
        data_nx  = bitlen[31:0];
        last_nx  = 1'b1;
        state_nx = S_BLK;
      end
      S_BLK: begin
        blk_nx = 1'b1;
        msg_nx = last;
        if (last) begin
          cnt_nx  = '0;
          p_nx    = 6'd0;
          last_nx = 1'b0;
        end
        state_nx = S_WAIT;
      end
      default: state_nx = S_WAIT;
    endcase
  end

  // Registered state and outputs (one cycle behind the decision)
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= S_WAIT;
      p        <= 6'd0;
      cnt      <= '0;
      zw       <= 5'd0;
      tgt      <= 5'd0;
      pend_pad <= 1'b0;
      pend_ovf <= 1'b0;
      last     <= 1'b0;
      err      <= 1'b0;
      out_wr   <= 1'b0;
      out_addr <= 4'd0;
      out_en   <= 4'd0;
      out_data <= 32'd0;
      blk_done <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      state    <= state_nx;
      p        <= p_nx;
      cnt      <= cnt_nx;
      zw       <= zw_nx;
      tgt      <= tgt_nx;
      pend_pad <= pend_pad_nx;
      pend_ovf <= pend_ovf_nx;
      last     <= last_nx;
      err      <= err_nx;
      out_wr   <= wr_nx;
      out_addr <= addr_nx;
      out_en   <= en_nx;
      out_data <= data_nx;
      blk_done <= blk_nx;
      msg_done <= msg_nx;
    end
  end

endmodule

// File: tb/tb_sha256_byte_packer.sv
// Directed bench for sha256_byte_packer: models the byte-enable block buffer,
// snapshots it on every blk_done, and checks snapshots against hand values.
module tb_sha256_byte_packer;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        msg_empty = 1'b0;
  logic        buf_free;
  logic        out_wr;
  logic [3:0]  out_addr;
  logic [3:0]  out_en;
  logic [31:0] out_data;
  logic        blk_done;
  logic        msg_done;
  logic        err;

  logic        bf_en = 1'b0;
  logic        prefill = 1'b0;
  int          nblk = 0;
  int          nmsg = 0;
  int          blk_ack = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [16];
  logic [31:0] snap [8][16];
  logic        snap_last [8];

  // downstream drops buf_free as soon as it sees a block until it is re-granted
  assign buf_free = bf_en && (nblk == blk_ack);

  sha256_byte_packer #(.LEN_W(16)) dut (
    .CLK(CLK), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .msg_empty(msg_empty),
    .buf_free(buf_free), .out_wr(out_wr), .out_addr(out_addr),
    .out_en(out_en), .out_data(out_data), .blk_done(blk_done),
    .msg_done(msg_done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Block buffer model and block snapshots
  always @(negedge CLK) begin
    if (prefill) begin
      for (int j = 0; j < 16; j++) mem[j] <= 32'hDEAD_BEEF;
    end else if (!rst) begin
      if (out_wr)
        for (int k = 0; k < 4; k++)
          if (out_en[k]) mem[out_addr][8*k +: 8] <= out_data[8*k +: 8];
      if (blk_done) begin
        for (int j = 0; j < 16; j++) snap[nblk[2:0]][j] <= mem[j];
        snap_last[nblk[2:0]] <= msg_done;
        nblk <= nblk + 1;
      end
      if (msg_done) nmsg <= nmsg + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_prefill();
    @(negedge CLK); prefill = 1'b1;
    @(negedge CLK); prefill = 1'b0;
  endtask

  task automatic grant();
    @(negedge CLK);
    blk_ack = nblk;
    bf_en   = 1'b1;
  endtask

  task automatic send_bytes(input int n, input bit is_abc, input bit with_last);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = is_abc ? 8'(8'h61 + i) : 8'h41;
      in_last  = with_last && (i == n - 1);
      if (in_ready) i++;
      guard++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic wait_blk(input int target);
    int g = 0;
    while (nblk < target && g < 500) begin @(negedge CLK); g++; end
    if (nblk < target) chk("blk_timeout", nblk, target);
  endtask

  task automatic wait_msg(input int target);
    int g = 0;
    while (nmsg < target && g < 500) begin @(negedge CLK); g++; end
    if (nmsg < target) chk("msg_timeout", nmsg, target);
  endtask

  task automatic check_block(input string t, input int idx, input logic [31:0] w0,
                             input logic [31:0] mid, input logic [31:0] w13,
                             input logic [31:0] w14, input logic [31:0] w15,
                             input logic lst);
    logic [31:0] exp;
    for (int j = 0; j < 16; j++) begin
      exp = (j == 0) ? w0 : (j == 13) ? w13 : (j == 14) ? w14 : (j == 15) ? w15 : mid;
      chk($sformatf("%s_w%0d", t, j), snap[idx[2:0]][j], exp);
    end
    chk({t, "_msg_done"}, 32'(snap_last[idx[2:0]]), 32'(lst));
  endtask

  initial begin
    int b0;
    int m0;
    int stall_bad;

    repeat (3) @(negedge CLK);
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_en", 32'(out_en), 32'd0);
    chk("rst_blk_done", 32'(blk_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // "abc"
    do_prefill();
    b0 = nblk; m0 = nmsg;
    grant();
    send_bytes(3, 1'b1, 1'b1);
    wait_msg(m0 + 1);
    repeat (3) @(negedge CLK);
    chk("abc_blk_count", nblk, b0 + 1);
    check_block("abc", b0, 32'h61626380, 32'd0, 32'd0, 32'd0, 32'h18, 1'b1);

    // zero-length message
    do_prefill();
    b0 = nblk; m0 = nmsg;
    grant();
    repeat (2) @(negedge CLK);
    msg_empty = 1'b1;
    @(negedge CLK);
    msg_empty = 1'b0;
    wait_msg(m0 + 1);
    repeat (3) @(negedge CLK);
    chk("empty_blk_count", nblk, b0 + 1);
    check_block("empty", b0, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);

    // 55 bytes: pad and length fit in one block
    do_prefill();
    b0 = nblk; m0 = nmsg;
    grant();
    send_bytes(55, 1'b0, 1'b1);
    wait_msg(m0 + 1);
    repeat (3) @(negedge CLK);
    chk("b55_blk_count", nblk, b0 + 1);
    check_block("b55", b0, 32'h41414141, 32'h41414141, 32'h41414180, 32'd0, 32'h1B8, 1'b1);

    // 56 bytes: pad overflows into a second block
    do_prefill();
    b0 = nblk; m0 = nmsg;
    grant();
    send_bytes(56, 1'b0, 1'b1);
    wait_blk(b0 + 1);
    repeat (6) @(negedge CLK);
    check_block("b56_1", b0, 32'h41414141, 32'h41414141, 32'h41414141, 32'h80000000, 32'd0, 1'b0);
    chk("b56_hold_w14", mem[14], 32'h80000000);
    chk("b56_hold_msgs", nmsg, m0);
    chk("b56_hold_ready", 32'(in_ready), 32'd0);
    grant();
    wait_msg(m0 + 1);
    repeat (3) @(negedge CLK);
    chk("b56_blk_count", nblk, b0 + 2);
    check_block("b56_2", b0 + 1, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1C0, 1'b1);

    // 64 bytes: last byte fills the block, padding goes to the next one
    do_prefill();
    b0 = nblk; m0 = nmsg;
    grant();
    send_bytes(64, 1'b0, 1'b1);
    wait_blk(b0 + 1);
    stall_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (in_ready || out_wr) stall_bad++;
    end
    chk("b64_stall_quiet", stall_bad, 0);
    chk("b64_hold_msgs", nmsg, m0);
    check_block("b64_1", b0, 32'h41414141, 32'h41414141, 32'h41414141, 32'h41414141, 32'h41414141, 1'b0);
    grant();
    wait_msg(m0 + 1);
    repeat (3) @(negedge CLK);
    chk("b64_blk_count", nblk, b0 + 2);
    check_block("b64_2", b0 + 1, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'h200, 1'b1);

    // reset mid-message, then "abc" again
    b0 = nblk; m0 = nmsg;
    grant();
    send_bytes(10, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk("midrst_out_wr", 32'(out_wr), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge CLK);
    chk("midrst_no_blk", nblk, b0);
    send_bytes(3, 1'b1, 1'b1);
    wait_msg(m0 + 1);
    repeat (3) @(negedge CLK);
    chk("abc2_blk_count", nblk, b0 + 1);
    check_block("abc2", b0, 32'h61626380, 32'd0, 32'd0, 32'd0, 32'h18, 1'b1);
    chk("final_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
